control_multiciclo: RTL and testbench
=====================================

Name: control_multiciclo

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences instruction fetch, decode, execute, memory and writeback.
- Drives PCWrite, PCWriteCond and PCWriteCondN into the PC write-enable logic, plus all mux selects and enables for memory, IR, ALU and register file.
- Stalls in memory-access states until the memory reports ready.

Parameters:
- OP_RTYPE, 6'h00, R-type opcode
- OP_LW, 6'h23, load word opcode
- OP_SW, 6'h2B, store word opcode
- OP_BEQ, 6'h04, branch-if-equal opcode
- OP_BNE, 6'h05, branch-if-not-equal opcode
- OP_J, 6'h02, jump opcode
- OP_ADDI, 6'h08, add-immediate opcode

Ports:
- clk  in  1  system clock; state updates on rising edge
- reset  in  1  synchronous, active-high reset
- Op  in  6  opcode field, IR[31:26]
- MemReady  in  1  memory access completes this cycle
- PCWrite, PCWriteCond, PCWriteCondN  out  1 each  PC write controls
- IorD, MemRead, MemWrite, IRWrite  out  1 each  memory/IR controls
- MemtoReg, RegDst, RegWrite  out  1 each  register file controls
- ALUSrcA  out  1  ALU A select: 0=PC, 1=A
- ALUSrcB  out  2  ALU B select: 00=B, 01=4, 10=signext, 11=signext<<2
- ALUOp  out  2  00=add, 01=sub, 10=funct
- PCSource  out  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
- IllegalOp  out  1  unknown opcode seen in DECODE
- State  out  4  current state, for debug

Behaviour:
- State register, 4 bits. Encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, ALUWB=7, BEQ=8, BNE=9, JUMP=10, ADDIEX=11, ADDIWB=12
- Reset:
  - reset=1 at a rising edge sets State to FETCH, from any state including mid-access.
  - While reset=1, every output except State is forced to 0.
- Outputs are decoded combinationally from State; Op and MemReady also feed in where noted below.
- Any output not listed for a state is 0.
- Unused encodings 13-15 drive all-zero outputs and go to FETCH next cycle.
- Per-state outputs and next state:
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=MemReady. Next DECODE if MemReady, else stay in FETCH; the PC increments exactly once per fetch.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute). Next by Op:
    - LW or SW -> MEMADR
    - RTYPE -> EXEC
    - BEQ -> BEQ
    - BNE -> BNE
    - J -> JUMP
    - ADDI -> ADDIEX
    - any other Op -> FETCH with IllegalOp=1 for that cycle only
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next MEMRD if Op=LW, else MEMWR.
  - MEMRD: MemRead=1, IorD=1. Stays until MemReady=1, then MEMWB.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next FETCH.
  - MEMWR: MemWrite=1, IorD=1. Stays until MemReady=1, then FETCH. MemWrite is held high for every waiting cycle.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next ALUWB.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next FETCH.
  - BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWriteCond=1. Next FETCH.
  - BNE: same as BEQ except PCWriteCondN=1 instead of PCWriteCond. Next FETCH.
  - JUMP: PCWrite=1, PCSource=10. Next FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next ADDIWB.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next FETCH.
- Invariants:
  - At most one of PCWrite, PCWriteCond and PCWriteCondN is high in any cycle.
  - MemRead and MemWrite are never both high.
- Instruction latency with MemReady tied high:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type and addi: 4 cycles
  - beq, bne, j: 3 cycles
- Each stalled memory cycle adds 1 cycle to the instruction.

Test Plan:
- Reset then idle: hold reset=1 for 2 cycles with MemReady=0 -> all outputs 0 and State=0 during reset. After release, State stays 0 with MemRead=1, PCWrite=0 and IRWrite=0.
- lw with wait states: Op=6'h23; MemReady=1 during FETCH; MemReady=0 for 2 cycles in MEMRD, then 1 -> State sequence 0,1,2,3,3,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4. PCWrite pulses once.
- beq/bne: Op=6'h04 then Op=6'h05, MemReady=1 -> states 0,1,8,0 then 0,1,9,0. In state 8: PCWriteCond=1, PCWriteCondN=0, ALUOp=01, PCSource=01. In state 9 the two condition signals are swapped.
- R-type and addi: Op=6'h00 -> states 0,1,6,7,0 with ALUOp=10 in 6 and RegDst=1 in 7. Op=6'h08 -> states 0,1,11,12,0 with ALUSrcB=10 in 11 and RegDst=0 in 12.
- j, sw and illegal opcode:
  - Op=6'h02 -> JUMP with PCWrite=1 and PCSource=10.
  - Op=6'h2B with MemReady=0 for 1 cycle in MEMWR -> MemWrite high for 2 cycles.
  - Op=6'h3F -> IllegalOp=1 in DECODE only, next state FETCH.
- Reset mid-operation: assert reset while in MEMRD with MemReady=0 -> State=0 at the next edge, and MemRead and IorD drop to 0 in the reset cycle.

Source files
------------

// File: rtl/control_multiciclo.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback, stalling memory states until MemReady.
module control_multiciclo #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_BNE   = 6'h05,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter logic [5:0] OP_ADDI  = 6'h08
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCondN,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_BNE    = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign State = state_q;

  always_comb begin
    state_d      = S_FETCH;
    PCWrite      = 1'b0;
    PCWriteCond  = 1'b0;
    PCWriteCondN = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    MemtoReg     = 1'b0;
    RegDst       = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ALUOp        = 2'b00;
    PCSource     = 2'b00;
    IllegalOp    = 1'b0;
    case (state_q)
      S_FETCH: begin
        // IR load and PC+4 commit only on the cycle the fetch completes
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
        state_d = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_BNE:       state_d = S_BNE;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            state_d   = S_FETCH;
            IllegalOp = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = MemReady ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = MemReady ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCSource    = 2'b01;
        PCWriteCond = 1'b1;
      end
      S_BNE: begin
        ALUSrcA      = 1'b1;
        ALUOp        = 2'b01;
        PCSource     = 2'b01;
        PCWriteCondN = 1'b1;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset quiets every control line; State still reflects the register
    if (reset) begin
      PCWrite      = 1'b0;
      PCWriteCond  = 1'b0;
      PCWriteCondN = 1'b0;
      IorD         = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      MemtoReg     = 1'b0;
      RegDst       = 1'b0;
      RegWrite     = 1'b0;
      ALUSrcA      = 1'b0;
      ALUSrcB      = 2'b00;
      ALUOp        = 2'b00;
      PCSource     = 2'b00;
      IllegalOp    = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_multiciclo.sv
// Bench for control_multiciclo: directed and random instruction traces checked
// against a per-instruction state-sequence model and a per-state control table.
module tb_control_multiciclo;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, PCWriteCondN;
  logic       IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       IllegalOp;
  logic [3:0] State;

  typedef struct packed {
    logic       pcw, pcwc, pcwcn, iord, mrd, mwr, irw, m2r, rdst, rw, srcA;
    logic [1:0] srcB, aluop, pcsrc;
    logic       illegal;
  } ctrl_t;

  int checks = 0;
  int errors = 0;

  control_multiciclo dut (
    .clk(clk), .reset(reset), .Op(Op), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteCondN(PCWriteCondN),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .IllegalOp(IllegalOp), .State(State)
  );

  always #5 clk = ~clk;

  function automatic bit isKnown(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08};
  endfunction

  // Control word the datapath needs in each step of an instruction
  function automatic ctrl_t model(input int st, input logic [5:0] op,
                                  input logic mr, input logic rst);
    ctrl_t c;
    c = '0;
    if (rst) return c;
    case (st)
      0:  begin c.mrd = 1; c.srcB = 2'b01; c.irw = mr; c.pcw = mr; end
      1:  begin c.srcB = 2'b11; c.illegal = !isKnown(op); end
      2:  begin c.srcA = 1; c.srcB = 2'b10; end
      3:  begin c.mrd = 1; c.iord = 1; end
      4:  begin c.m2r = 1; c.rw = 1; end
      5:  begin c.mwr = 1; c.iord = 1; end
      6:  begin c.srcA = 1; c.aluop = 2'b10; end
      7:  begin c.rdst = 1; c.rw = 1; end
      8:  begin c.srcA = 1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.pcwc = 1; end
      9:  begin c.srcA = 1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.pcwcn = 1; end
      10: begin c.pcw = 1; c.pcsrc = 2'b10; end
      11: begin c.srcA = 1; c.srcB = 2'b10; end
      12: begin c.rw = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic applyStimulus(input logic [5:0] op, input logic mr, input logic rst);
    @(negedge clk);
    Op       = op;
    MemReady = mr;
    reset    = rst;
    #1;
  endtask

  task automatic checkOutput(input string tag, input int expState, input ctrl_t expCtrl);
    ctrl_t act;
    act = '{PCWrite, PCWriteCond, PCWriteCondN, IorD, MemRead, MemWrite, IRWrite,
            MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp};
    checks++;
    assert (State === 4'(expState)) else begin
      errors++;
      $error("FAIL %s state: observed %0d expected %0d", tag, State, expState);
    end
    checks++;
    assert (act === expCtrl) else begin
      errors++;
      $error("FAIL %s ctrl (state %0d): observed %b expected %b", tag, expState, act, expCtrl);
    end
    checks++;
    assert ($onehot0({PCWrite, PCWriteCond, PCWriteCondN}) && !(MemRead && MemWrite)) else begin
      errors++;
      $error("FAIL %s invariant: observed pcw=%b%b%b rd/wr=%b%b expected onehot0 and not both",
             tag, PCWrite, PCWriteCond, PCWriteCondN, MemRead, MemWrite);
    end
  endtask

  // Expected trace: fetch (with stalls), decode, then the opcode's own steps
  task automatic runInstr(input string tag, input logic [5:0] op, input int fw, input int mw);
    int  stQ[$];
    bit  mrQ[$];
    int  pcwCount = 0;
    int  expPcw;
    for (int i = 0; i < fw; i++) begin stQ.push_back(0); mrQ.push_back(1'b0); end
    stQ.push_back(0); mrQ.push_back(1'b1);
    stQ.push_back(1); mrQ.push_back(1'($urandom));
    case (op)
      6'h23, 6'h2B: begin
        stQ.push_back(2); mrQ.push_back(1'($urandom));
        for (int i = 0; i < mw; i++) begin
          stQ.push_back(op == 6'h23 ? 3 : 5); mrQ.push_back(1'b0);
        end
        stQ.push_back(op == 6'h23 ? 3 : 5); mrQ.push_back(1'b1);
        if (op == 6'h23) begin stQ.push_back(4); mrQ.push_back(1'($urandom)); end
      end
      6'h00: begin stQ.push_back(6); stQ.push_back(7); mrQ.push_back(1'($urandom)); mrQ.push_back(1'($urandom)); end
      6'h08: begin stQ.push_back(11); stQ.push_back(12); mrQ.push_back(1'($urandom)); mrQ.push_back(1'($urandom)); end
      6'h04: begin stQ.push_back(8); mrQ.push_back(1'($urandom)); end
      6'h05: begin stQ.push_back(9); mrQ.push_back(1'($urandom)); end
      6'h02: begin stQ.push_back(10); mrQ.push_back(1'($urandom)); end
      default: ;
    endcase
    foreach (stQ[i]) begin
      applyStimulus(op, mrQ[i], 1'b0);
      checkOutput(tag, stQ[i], model(stQ[i], op, mrQ[i], 1'b0));
      if (PCWrite === 1'b1) pcwCount++;
    end
    expPcw = (op == 6'h02) ? 2 : 1;
    checks++;
    assert (pcwCount == expPcw) else begin
      errors++;
      $error("FAIL %s pcwrite-count: observed %0d expected %0d", tag, pcwCount, expPcw);
    end
  endtask

  initial begin
    logic [5:0] ops[7];
    logic [5:0] op;
    reset = 1'b1; Op = 6'h00; MemReady = 1'b0;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08};

    applyStimulus(6'h00, 1'b0, 1'b1);
    checkOutput("reset1", 0, model(0, 6'h00, 1'b0, 1'b1));
    applyStimulus(6'h00, 1'b0, 1'b1);
    checkOutput("reset2", 0, model(0, 6'h00, 1'b0, 1'b1));
    applyStimulus(6'h00, 1'b0, 1'b0);
    checkOutput("idle1", 0, model(0, 6'h00, 1'b0, 1'b0));
    applyStimulus(6'h00, 1'b0, 1'b0);
    checkOutput("idle2", 0, model(0, 6'h00, 1'b0, 1'b0));

    runInstr("lw_wait2", 6'h23, 0, 2);
    runInstr("beq", 6'h04, 0, 0);
    runInstr("bne", 6'h05, 0, 0);
    runInstr("rtype", 6'h00, 0, 0);
    runInstr("addi", 6'h08, 0, 0);
    runInstr("j", 6'h02, 0, 0);
    runInstr("sw_wait1", 6'h2B, 0, 1);
    runInstr("illegal3F", 6'h3F, 0, 0);
    runInstr("lw_nowait", 6'h23, 1, 0);

    applyStimulus(6'h23, 1'b1, 1'b0); checkOutput("midrst", 0, model(0, 6'h23, 1'b1, 1'b0));
    applyStimulus(6'h23, 1'b0, 1'b0); checkOutput("midrst", 1, model(1, 6'h23, 1'b0, 1'b0));
    applyStimulus(6'h23, 1'b0, 1'b0); checkOutput("midrst", 2, model(2, 6'h23, 1'b0, 1'b0));
    applyStimulus(6'h23, 1'b0, 1'b0); checkOutput("midrst", 3, model(3, 6'h23, 1'b0, 1'b0));
    applyStimulus(6'h23, 1'b0, 1'b1); checkOutput("midrst_asserted", 3, model(3, 6'h23, 1'b0, 1'b1));
    applyStimulus(6'h23, 1'b0, 1'b1); checkOutput("midrst_edge", 0, model(0, 6'h23, 1'b0, 1'b1));
    applyStimulus(6'h23, 1'b0, 1'b0); checkOutput("midrst_release", 0, model(0, 6'h23, 1'b0, 1'b0));

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        op = 6'($urandom_range(0, 63));
        for (int k = 0; k < 64 && isKnown(op); k++) op = op + 6'd1;
      end else begin
        op = ops[$urandom_range(0, 6)];
      end
      runInstr($sformatf("rand%0d_op%02h", n, op), op, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    applyStimulus(6'h00, 1'b0, 1'b0);
    checkOutput("final_fetch", 0, model(0, 6'h00, 1'b0, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
